// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART receiver state encoding and per-bit sampling edge helpers
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;
  function automatic int sample_edge(input int prescale);
    return prescale / 2 + 2;
  endfunction
  function automatic int last_edge(input int prescale);
    return prescale - 1;
  endfunction
endpackage

// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: line/checker inputs and sequencing outputs of the receiver FSM
interface uart_rx_fsm_if #(parameter int PRESCALE = 8);
  logic rx_in, par_en, strt_glitch, par_err, stp_err;
  logic [$clog2(PRESCALE)-1:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid, busy;
  modport master (
    input  rx_in, par_en, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
           data_valid, busy
  );
  modport slave (
    output rx_in, par_en, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
           data_valid, busy
  );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// uart_rx_edge_bit_counter: oversampling edge counter and data-bit counter
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cnt_en,
  input  logic                        bit_inc,
  input  logic                        bit_clr,
  output logic [$clog2(PRESCALE)-1:0] edge_cnt,
  output logic [3:0]                  bit_cnt
);
  localparam int EW = $clog2(PRESCALE);
  localparam logic [EW-1:0] LAST = EW'(last_edge(PRESCALE));
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      edge_cnt <= (cnt_en && edge_cnt != LAST) ? edge_cnt + 1'b1 : '0;
      bit_cnt  <= bit_clr ? '0 : bit_inc ? bit_cnt + 1'b1 : bit_cnt;
    end
  end
endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receiver control FSM sequencing checker and deserializer enables
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fsm_if.master bus
);
  localparam int EW = $clog2(PRESCALE);
  localparam logic [EW-1:0] PRE_SAMPLE = EW'(sample_edge(PRESCALE) - 1);
  localparam logic [EW-1:0] LAST = EW'(last_edge(PRESCALE));
  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
  uart_rx_state_t state, state_n;
  logic [EW-1:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic par_en_q, at_last, pre_sample, busy;
  logic strt_chk_en, par_chk_en, stp_chk_en, deser_en;
  assign at_last    = edge_cnt == LAST;
  assign pre_sample = edge_cnt == PRE_SAMPLE;
  uart_rx_edge_bit_counter #(.PRESCALE(PRESCALE)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .cnt_en   (state != IDLE),
    .bit_inc  (state == DATA && at_last),
    .bit_clr  (state == START && state_n == DATA),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.rx_in ? IDLE : START;
      START:   state_n = !at_last ? START : bus.strt_glitch ? IDLE : DATA;
      DATA:    state_n = !(at_last && bit_cnt == LAST_BIT) ? DATA : par_en_q ? PARITY : STOP;
      PARITY:  state_n = !at_last ? PARITY : bus.par_err ? IDLE : STOP;
      STOP:    state_n = at_last ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // Enables are decoded one edge early so the registered pulse lands on the sample edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      par_en_q    <= 1'b0;
      busy        <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      deser_en    <= 1'b0;
    end else begin
      state       <= state_n;
      par_en_q    <= (state == IDLE && !bus.rx_in) ? bus.par_en : par_en_q;
      busy        <= state_n != IDLE;
      strt_chk_en <= state == START  && pre_sample;
      par_chk_en  <= state == PARITY && pre_sample;
      stp_chk_en  <= state == STOP   && pre_sample;
      deser_en    <= state == DATA   && pre_sample;
    end
  end
  // Checker errors only settle on the last edge, so data_valid decodes them directly.
  assign bus.data_valid  = state == STOP && at_last && !bus.stp_err && (!par_en_q || !bus.par_err);
  assign bus.edge_cnt    = edge_cnt;
  assign bus.bit_cnt     = bit_cnt;
  assign bus.busy        = busy;
  assign bus.dat_samp_en = busy;
  assign bus.strt_chk_en = strt_chk_en;
  assign bus.par_chk_en  = par_chk_en;
  assign bus.stp_chk_en  = stp_chk_en;
  assign bus.deser_en    = deser_en;
endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Control state machine for the UART receiver. It detects the start bit and runs the oversampling edge counter and the bit counter. It issues single-cycle enable pulses to the start, parity and stop checkers and to the deserializer, then raises data_valid for frames that pass every check. It sits between the rx_in pin sampler and the checker/deserializer datapath blocks.

## Interface
- PRESCALE, 8: oversampling ratio, clocks per bit; legal values 8, 16, 32.
- DATA_WIDTH, 8: data bits per frame; legal range 5–8.
- clk  in  1  receiver oversampling clock.
- rst  in  1  synchronous reset, active-high.
- rx_in  in  1  serial line, already synchronized; idle = 1.
- par_en  in  1  frame carries a parity bit; captured on IDLE→START, ignored mid-frame.
- strt_glitch  in  1  registered start-checker result; 1 = start bit sampled high.
- par_err  in  1  registered parity-checker result.
- stp_err  in  1  registered stop-checker result.
- edge_cnt  out  $clog2(PRESCALE)  clock index within the current bit, 0..PRESCALE-1.
- bit_cnt  out  4  data-bit index, 0..DATA_WIDTH-1.
- dat_samp_en  out  1  enables the majority-vote sampler.
- strt_chk_en, par_chk_en, stp_chk_en, deser_en  out  1 each  one-cycle pulses.
- data_valid  out  1  one-cycle pulse; deserializer output is a good byte.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Encoding is in the package.
- Local constants:
  - SAMPLE_EDGE = PRESCALE/2+2. The sampler's 3-sample majority is ready here.
  - LAST_EDGE = PRESCALE-1.
- edge_cnt:
  - Held at 0 in IDLE.
  - In every other state it increments each cycle and wraps LAST_EDGE→0.
- bit_cnt:
  - Cleared on entry to DATA.
  - Increments at LAST_EDGE in DATA.
  - Held in every other state.
- IDLE:
  - If rx_in==0, go to START; edge_cnt is 0 in the first START cycle.
  - Latch par_en into par_en_q on this transition.
- START:
  - strt_chk_en pulses when edge_cnt==SAMPLE_EDGE.
  - At LAST_EDGE: if strt_glitch, go to IDLE (frame discarded); otherwise go to DATA.
- DATA:
  - deser_en pulses when edge_cnt==SAMPLE_EDGE.
  - At LAST_EDGE with bit_cnt==DATA_WIDTH-1: go to PARITY if par_en_q, otherwise go to STOP.
- PARITY:
  - par_chk_en pulses at SAMPLE_EDGE.
  - At LAST_EDGE: if par_err, go to IDLE (no data_valid); otherwise go to STOP.
- STOP:
  - stp_chk_en pulses at SAMPLE_EDGE.
  - At LAST_EDGE, go to IDLE.
  - data_valid pulses in that same cycle iff !stp_err and (!par_en_q or !par_err).
- dat_samp_en = busy.
- Enables are registered, Moore-style, and decoded from state and edge_cnt.
- The checkers register their error one cycle after the enable, so the error is stable by LAST_EDGE (SAMPLE_EDGE+1 ≤ LAST_EDGE for every legal PRESCALE).

## Timing
- Reset values: state=IDLE, edge_cnt=0, bit_cnt=0, par_en_q=0, all enables=0, data_valid=0, busy=0.
- Reset asserted mid-frame:
  - Next clk returns to IDLE with all outputs at their reset values.
  - No data_valid is issued.
- Frame length, start-detect cycle to the data_valid cycle: (1 + DATA_WIDTH + par_en_q + 1) × PRESCALE cycles.
  - Example: PRESCALE=8, DATA_WIDTH=8, parity on → 88 cycles.
- Back-to-back frames:
  - IDLE samples rx_in on the cycle after STOP's LAST_EDGE.
  - A start edge arriving during STOP is detected with ≤1 cycle lag.
- rx_in low for a whole frame of zeros (stop bit sampled 0):
  - stp_err is set, so no data_valid.
  - FSM returns to IDLE, then immediately re-enters START because rx_in==0. This is the required behaviour (break condition).
- Each enable pulse is exactly 1 cycle wide. At most one enable is high in any cycle.

## Structure
- Package uart_rx_pkg holds:
  - the state enum `uart_rx_state_t`;
  - functions for SAMPLE_EDGE and LAST_EDGE derived from PRESCALE.
- The data_sampling and checker blocks import uart_rx_pkg for the same sample-edge constants.
- Sub-module uart_rx_edge_bit_counter holds edge_cnt and bit_cnt, controlled by cnt_en, bit_inc and bit_clr from the FSM.
- The FSM and enable decode live in uart_rx_fsm.

## Test plan
- PRESCALE=8, par_en=0, frame 0xA5 with good stop bit:
  - Exactly 8 deser_en pulses, at edge 6 of each data bit.
  - data_valid at cycle 80 after the start edge.
  - busy drops the next cycle.
- par_en=1 with par_err driven 1 from the PARITY enable onward:
  - par_chk_en pulses once.
  - FSM returns to IDLE at parity LAST_EDGE.
  - No stp_chk_en and no data_valid.
- rx_in low pulse of 3 cycles with strt_glitch=1:
  - strt_chk_en pulses at edge 6.
  - Return to IDLE at edge 7.
  - deser_en never asserts.
- stp_err=1 in STOP: stp_chk_en pulses, data_valid stays 0, state=IDLE after edge 7.
- rst asserted in DATA with bit_cnt=3:
  - All outputs are 0 on the next clk.
  - A subsequent clean frame produces data_valid normally.
- Two back-to-back frames with par_en toggled mid-frame:
  - Each frame uses the par_en value latched at its own start.
  - Two data_valid pulses occur, 80 and 88 cycles after their respective start edges.
